// File: rtl/fs_dither_stream_if.sv
// Stream bundle for fs_dither_stream: raster-order input pixels and dithered output pixels.
// The design uses the slave view; a producer/consumer pair uses the master view.
interface fs_dither_stream_if #(
    parameter int RGB_SIZE = 8,
    parameter int OUT_BITS = 1
);
    logic                in_valid;
    logic                in_ready;
    logic [RGB_SIZE-1:0] in_pixel;
    logic                out_valid;
    logic                out_ready;
    logic [RGB_SIZE-1:0] out_pixel;
    logic [OUT_BITS-1:0] out_index;

    modport slave (
        input  in_valid, in_pixel, out_ready,
        output in_ready, out_valid, out_pixel, out_index
    );

    modport master (
        output in_valid, in_pixel, out_ready,
        input  in_ready, out_valid, out_pixel, out_index
    );
endinterface

// File: rtl/fs_dither_stream.sv
// Streaming Floyd-Steinberg error-diffusion quantiser, one pixel per accepted transfer.
// Optional FS_SERPENTINE_EN: odd rows arrive right-to-left and use the mirrored kernel.
module fs_dither_stream #(
    parameter int IMAGEX   = 4,
    parameter int IMAGEY   = 4,
    parameter int RGB_SIZE = 8,
    parameter int OUT_BITS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    fs_dither_stream_if.slave strm,
    output logic              busy,
    output logic              frame_done
);
    localparam int NPIX = IMAGEX * IMAGEY;
    localparam int XW   = $clog2(IMAGEX);
    localparam int YW   = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;
    localparam int CW   = $clog2(NPIX + 1);
    localparam int AW   = RGB_SIZE + 6;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [XW-1:0]        x_q, x_d;
    logic [YW-1:0]        y_q, y_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [AW-1:0] carry_q, carry_d;
    logic signed [AW-1:0] se_q, se_d;
    logic signed [AW-1:0] row_q [IMAGEX];
    logic signed [AW-1:0] row_d [IMAGEX];
    logic                 out_valid_q, out_valid_d;
    logic [RGB_SIZE-1:0]  out_pixel_q, out_pixel_d;
    logic [OUT_BITS-1:0]  out_index_q, out_index_d;
    logic                 busy_q, frame_done_q;

    logic                 rev_s, first_s, last_col_s, last_row_s;
    logic                 in_ready_s, accept_s, out_hs_s;
    logic [XW-1:0]        xpos_s, prev_x_s;
    logic signed [AW-1:0] acc_s, adj_w_s, err_s, err3_s, err5_s, err7_s;
    logic [RGB_SIZE-1:0]  adj_s, qpix_s;
    logic [OUT_BITS-1:0]  index_s;

    function automatic logic [RGB_SIZE-1:0] replicate(input logic [OUT_BITS-1:0] idx);
        logic [RGB_SIZE-1:0] r;
        r = '0;
        for (int b = 0; b < RGB_SIZE; b++) begin
            r[RGB_SIZE-1-b] = idx[OUT_BITS-1-(b % OUT_BITS)];
        end
        return r;
    endfunction

    // Position decode, handshakes and the quantise/error datapath for the pixel on in_pixel.
    always_comb begin
        rev_s = 1'b0;
`ifdef FS_SERPENTINE_EN
        rev_s = y_q[0];
`endif
        xpos_s     = rev_s ? (XW'(IMAGEX - 1) - x_q) : x_q;
        prev_x_s   = rev_s ? (xpos_s + XW'(1)) : (xpos_s - XW'(1));
        first_s    = (x_q == '0);
        last_col_s = (x_q == XW'(IMAGEX - 1));
        last_row_s = (y_q == YW'(IMAGEY - 1));
        in_ready_s = (state_q == S_RUN) && (!out_valid_q || strm.out_ready) && (cnt_q < CW'(NPIX));
        accept_s   = strm.in_valid && in_ready_s;
        out_hs_s   = out_valid_q && strm.out_ready;

        acc_s   = row_q[xpos_s] + carry_q;
        adj_w_s = $signed({{(AW-RGB_SIZE){1'b0}}, strm.in_pixel}) + (acc_s >>> 3'd4);
        if (adj_w_s[AW-1]) begin
            adj_s = '0;
        end else if (|adj_w_s[AW-2:RGB_SIZE]) begin
            adj_s = '1;
        end else begin
            adj_s = adj_w_s[RGB_SIZE-1:0];
        end
        index_s = adj_s[RGB_SIZE-1 -: OUT_BITS];
        qpix_s  = replicate(index_s);
        err_s   = $signed({{(AW-RGB_SIZE){1'b0}}, adj_s}) - $signed({{(AW-RGB_SIZE){1'b0}}, qpix_s});
        err3_s  = (err_s <<< 2'd1) + err_s;
        err5_s  = (err_s <<< 2'd2) + err_s;
        err7_s  = (err_s <<< 2'd3) - err_s;
    end

    // Next-state: FSM, raster counters, error buffers and the one-deep output register.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        se_d        = se_q;
        row_d       = row_q;
        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;
        out_index_d = out_index_q;

        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN; else state_d = S_IDLE;
            S_RUN:   if (out_hs_s && (cnt_q == CW'(NPIX))) state_d = S_DONE; else state_d = S_RUN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if ((state_q == S_IDLE) && start) begin
            x_d     = '0;
            y_d     = '0;
            cnt_d   = '0;
            carry_d = '0;
            se_d    = '0;
            for (int i = 0; i < IMAGEX; i++) begin
                row_d[i] = '0;
            end
        end else if (accept_s) begin
            cnt_d = cnt_q + CW'(1);
            if (last_col_s) begin
                x_d     = '0;
                y_d     = last_row_s ? '0 : (y_q + YW'(1));
                carry_d = '0;
                se_d    = '0;
            end else begin
                x_d     = x_q + XW'(1);
                carry_d = err7_s;
                se_d    = err_s;
            end
            // The row slot is rewritten as soon as it is read: it then holds the next row's sum.
            if (!last_row_s) begin
                if (!first_s) begin
                    row_d[prev_x_s] = row_q[prev_x_s] + err3_s;
                end else begin
                    row_d = row_q;
                end
                row_d[xpos_s] = err5_s + se_q;
            end else begin
                row_d = row_q;
            end
        end else begin
            cnt_d = cnt_q;
        end

        if (accept_s) begin
            out_valid_d = 1'b1;
            out_pixel_d = qpix_s;
            out_index_d = index_s;
        end else if (strm.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            y_q          <= '0;
            cnt_q        <= '0;
            carry_q      <= '0;
            se_q         <= '0;
            for (int i = 0; i < IMAGEX; i++) begin
                row_q[i] <= '0;
            end
            out_valid_q  <= 1'b0;
            out_pixel_q  <= '0;
            out_index_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            cnt_q        <= cnt_d;
            carry_q      <= carry_d;
            se_q         <= se_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_pixel_q  <= out_pixel_d;
            out_index_q  <= out_index_d;
            busy_q       <= (state_d != S_IDLE);
            frame_done_q <= (state_d == S_DONE);
        end
    end

    assign strm.in_ready  = in_ready_s;
    assign strm.out_valid = out_valid_q;
    assign strm.out_pixel = out_pixel_q;
    assign strm.out_index = out_index_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;
endmodule

// File: tb/tb_fs_dither_stream.sv
// Two DUTs (1-bit and 2-bit index) share one 4x4 input stream and are
// compared against a whole-frame 2-D Floyd-Steinberg model.
`timescale 1ns/1ps
module tb_fs_dither_stream;
    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;
`ifdef FS_SERPENTINE_EN
    localparam bit SERP = 1'b1;
`else
    localparam bit SERP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, start, in_valid, out_ready;
    logic [7:0] in_pixel;
    logic       busy_a, busy_b, fd_a, fd_b;

    int checks = 0;
    int errors = 0;

    logic [7:0] frame_px [N];
    int exp_pix [2][N];
    int exp_idx [2][N];
    int model_adj [2][N];
    int model_err [2][N];
    int rd_ptr [2];
    int fd_cnt [2];

    fs_dither_stream_if #(.RGB_SIZE(8), .OUT_BITS(1)) if_a();
    fs_dither_stream_if #(.RGB_SIZE(8), .OUT_BITS(2)) if_b();

    assign if_a.in_valid  = in_valid;
    assign if_a.in_pixel  = in_pixel;
    assign if_a.out_ready = out_ready;
    assign if_b.in_valid  = in_valid;
    assign if_b.in_pixel  = in_pixel;
    assign if_b.out_ready = out_ready;

    fs_dither_stream #(.IMAGEX(W), .IMAGEY(H), .RGB_SIZE(8), .OUT_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .strm(if_a), .busy(busy_a), .frame_done(fd_a));
    fs_dither_stream #(.IMAGEX(W), .IMAGEY(H), .RGB_SIZE(8), .OUT_BITS(2)) dut_b (
        .clk(clk), .reset(reset), .start(start), .strm(if_b), .busy(busy_b), .frame_done(fd_b));

    logic       m_ov [2], m_ir [2], m_fd [2], m_busy [2];
    logic [7:0] m_pix [2];
    logic [1:0] m_idx [2];
    assign m_ov[0]   = if_a.out_valid;
    assign m_ov[1]   = if_b.out_valid;
    assign m_ir[0]   = if_a.in_ready;
    assign m_ir[1]   = if_b.in_ready;
    assign m_fd[0]   = fd_a;
    assign m_fd[1]   = fd_b;
    assign m_busy[0] = busy_a;
    assign m_busy[1] = busy_b;
    assign m_pix[0]  = if_a.out_pixel;
    assign m_pix[1]  = if_b.out_pixel;
    assign m_idx[0]  = {1'b0, if_a.out_index};
    assign m_idx[1]  = if_b.out_index;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0d, required %0d", name, id, $signed(act), exp);
        end
    endtask

    // Whole-frame model: 2-D error array, floor division, clamp, replication by multiplication.
    task automatic build_expected();
        for (int k = 0; k < 2; k++) begin
            int acc [H][W];
            int ob;
            ob = k + 1;
            for (int y = 0; y < H; y++)
                for (int x = 0; x < W; x++) acc[y][x] = 0;
            for (int y = 0; y < H; y++) begin
                for (int j = 0; j < W; j++) begin
                    int x, d, n, a, q, adj, idx, rep, err;
                    bit rev;
                    rev = SERP && (y % 2 == 1);
                    x   = rev ? (W - 1 - j) : j;
                    d   = rev ? -1 : 1;
                    n   = y * W + j;
                    a   = acc[y][x];
                    q   = (a >= 0) ? (a / 16) : -((-a + 15) / 16);
                    adj = int'(frame_px[n]) + q;
                    if (adj < 0) adj = 0;
                    if (adj > 255) adj = 255;
                    idx = adj >> (8 - ob);
                    rep = idx * (255 / ((1 << ob) - 1));
                    err = adj - rep;
                    exp_pix[k][n]   = rep;
                    exp_idx[k][n]   = idx;
                    model_adj[k][n] = adj;
                    model_err[k][n] = err;
                    if (x + d >= 0 && x + d < W) acc[y][x + d] += 7 * err;
                    if (y + 1 < H) begin
                        if (x - d >= 0 && x - d < W) acc[y + 1][x - d] += 3 * err;
                        acc[y + 1][x] += 5 * err;
                        if (x + d >= 0 && x + d < W) acc[y + 1][x + d] += err;
                    end
                end
            end
        end
    endtask

    task automatic check_reset_outputs();
        for (int k = 0; k < 2; k++) begin
            chk("rst_in_ready", k, m_ir[k], 0);
            chk("rst_out_valid", k, m_ov[k], 0);
            chk("rst_out_pixel", k, m_pix[k], 0);
            chk("rst_out_index", k, m_idx[k], 0);
            chk("rst_busy", k, m_busy[k], 0);
            chk("rst_frame_done", k, m_fd[k], 0);
        end
    endtask

    task automatic idle_check();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        repeat (5) begin
            in_pixel = 8'($urandom);
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk("idle_in_ready", k, m_ir[k], 0);
                chk("idle_out_valid", k, m_ov[k], 0);
                chk("idle_busy", k, m_busy[k], 0);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    // mode 0: always ready/valid, 1: out_ready toggles, 2: random valid/ready.
    task automatic run_frame(input int mode, input int abort_after, input bit poke);
        int idx, cyc;
        bit acc, done;
        idx  = 0;
        cyc  = 0;
        done = 1'b0;
        build_expected();
        for (int k = 0; k < 2; k++) begin
            rd_ptr[k] = 0;
            fd_cnt[k] = 0;
        end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        while (!done && cyc < 400) begin
            cyc++;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = cyc[0];
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (idx < N) begin
                in_valid = (mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
                in_pixel = frame_px[idx];
            end else begin
                in_valid = 1'b1;
                in_pixel = 8'($urandom);
            end
            start = poke && (idx == 5);
            @(negedge clk);
            acc = in_valid && m_ir[0];
            if (idx >= N) begin
                chk("in_ready_after_last", 0, m_ir[0], 0);
                chk("in_ready_after_last", 1, m_ir[1], 0);
            end
            if (rd_ptr[0] < N) begin
                chk("busy_run", 0, m_busy[0], 1);
                chk("busy_run", 1, m_busy[1], 1);
            end
            @(posedge clk);
            #1;
            if (acc) idx++;
            if (abort_after > 0 && idx == abort_after) begin
                reset    = 1'b1;
                in_valid = 1'b0;
                start    = 1'b0;
                @(negedge clk);
                check_reset_outputs();
                @(posedge clk);
                #1;
                reset = 1'b0;
                return;
            end
            if (idx == N && !m_busy[0]) done = 1'b1;
        end
        start    = 1'b0;
        in_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: got %0d pixels accepted after %0d cycles, required frame end", idx, cyc);
        end else begin
            for (int k = 0; k < 2; k++) begin
                chk("pixels_out", k, rd_ptr[k], N);
                chk("done_pulses", k, fd_cnt[k], 1);
            end
        end
    endtask

    // Compare process: output order/values, stall stability, frame_done timing.
    initial begin
        bit         stall [2];
        bit         dnext [2];
        logic [7:0] ppix [2];
        logic [1:0] pidx [2];
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (reset) begin
                    stall[k] = 1'b0;
                    dnext[k] = 1'b0;
                end else begin
                    chk("frame_done", k, m_fd[k], int'(dnext[k]));
                    if (m_fd[k]) fd_cnt[k]++;
                    dnext[k] = 1'b0;
                    if (stall[k]) begin
                        chk("stall_valid", k, m_ov[k], 1);
                        chk("stall_pixel", k, m_pix[k], int'(ppix[k]));
                        chk("stall_index", k, m_idx[k], int'(pidx[k]));
                    end
                    if (m_ov[k] && out_ready) begin
                        if (rd_ptr[k] < N) begin
                            chk("out_pixel", k, m_pix[k], exp_pix[k][rd_ptr[k]]);
                            chk("out_index", k, m_idx[k], exp_idx[k][rd_ptr[k]]);
                            rd_ptr[k]++;
                            dnext[k] = (rd_ptr[k] == N);
                        end else begin
                            checks++;
                            errors++;
                            $display("FAIL extra_output dut%0d: got pixel %0d, required no output", k, m_pix[k]);
                        end
                    end
                    stall[k] = m_ov[k] && !out_ready;
                    ppix[k]  = m_pix[k];
                    pidx[k]  = m_idx[k];
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_pixel  = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_check();

        for (int i = 0; i < N; i++) frame_px[i] = 8'd0;
        run_frame(0, 0, 1'b0);
        chk("model_zero_last", 0, exp_pix[0][N-1], 0);

        for (int i = 0; i < N; i++) frame_px[i] = 8'd128;
        run_frame(0, 0, 1'b0);
        chk("model_pix00", 0, exp_pix[0][0], 255);
        chk("model_err00", 0, model_err[0][0], -127);
        chk("model_adj01", 0, model_adj[0][1], 72);
        chk("model_pix01", 0, exp_pix[0][1], 0);
        chk("model_pix00", 1, exp_pix[1][0], 170);

        repeat (4) begin
            for (int i = 0; i < N; i++) frame_px[i] = 8'($urandom);
            run_frame(2, 0, 1'b0);
        end

        for (int i = 0; i < N; i++) frame_px[i] = 8'($urandom);
        run_frame(1, 0, 1'b0);

        for (int i = 0; i < N; i++) frame_px[i] = 8'($urandom);
        run_frame(2, 7, 1'b0);
        idle_check();
        run_frame(2, 0, 1'b0);

        for (int i = 0; i < N; i++) frame_px[i] = 8'($urandom);
        run_frame(2, 0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fs_dither_stream.md
FS_DITHER_STREAM -- requirements
Module: fs_dither_stream

Interface
REQ-001 SHALL have parameter IMAGEX, default 4: pixels per row, at least 2.
REQ-002 SHALL have parameter IMAGEY, default 4: rows per frame, at least 1.
REQ-003 SHALL have parameter RGB_SIZE, default 8: input pixel width.
REQ-004 SHALL have parameter OUT_BITS, default 1: quantised index width, 1..RGB_SIZE-1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: begins a frame while idle.
REQ-008 SHALL have ports in_valid (input, 1), in_ready (output, 1) and in_pixel (input, RGB_SIZE): raster-order input stream.
REQ-009 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_pixel (output, RGB_SIZE) and out_index (output, OUT_BITS): dithered output stream.
REQ-010 SHALL have ports busy (output, 1) and frame_done (output, 1): status outputs.

Function
REQ-011 SHALL implement FSM IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on the out handshake of pixel IMAGEX*IMAGEY-1; DONE->IDLE after exactly 1 cycle.
REQ-012 SHALL ignore start outside IDLE; SHALL hold busy=1 in RUN and DONE; SHALL pulse frame_done=1 only in DONE.
REQ-013 SHALL define a transfer on either stream as valid&&ready in the same cycle.
REQ-014 SHALL drive in_ready = (state==RUN) && (!out_valid || out_ready) && (fewer than IMAGEX*IMAGEY pixels accepted).
REQ-015 SHALL present an accepted pixel on out_* exactly 1 cycle later and hold out_* stable while out_valid && !out_ready.
REQ-016 SHALL form adj = in_pixel + floor(acc/16), where acc is the signed accumulated error at that position, clamped to [0, 2^RGB_SIZE-1].
REQ-017 SHALL set out_index = adj[RGB_SIZE-1 -: OUT_BITS] and out_pixel = out_index bit-replicated to RGB_SIZE bits (OUT_BITS=1: adj>=128 gives 255, otherwise 0).
REQ-018 SHALL compute err = adj - out_pixel (signed, RGB_SIZE+1 bits) and add err*7 to E, err*3 to SW, err*5 to S and err*1 to SE.
REQ-019 SHALL discard error contributions that fall outside the frame (row edges and last row), and SHALL never wrap them to another row.
REQ-020 SHALL use accumulator width sufficient for 16*(2^RGB_SIZE) without overflow, and SHALL hold one row of next-row accumulators (IMAGEX entries) plus one current-row carry.
REQ-021 SHALL clear all accumulators on entering RUN.
REQ-022 SHALL, after the last pixel is accepted, hold in_ready=0 until IDLE, even when in_valid=1.

Reset
REQ-023 SHALL on reset, including mid-frame, force state IDLE; in_ready, out_valid, busy and frame_done to 0; out_pixel and out_index to 0; counters and accumulators to 0.
REQ-024 SHALL, after reset deasserts, process no pixel until a new start is received.

Configuration
REQ-025 SHALL support macro FS_SERPENTINE_EN: when defined, the producer supplies odd rows (y=1,3,...) right-to-left, the kernel is mirrored on those rows (E means x-1, SW means x+1, SE means x-1), and output order equals input order.
REQ-026 SHALL, when FS_SERPENTINE_EN is undefined, treat every row left-to-right with the unmirrored kernel.

Verification
REQ-027 SHALL be verified with a 4x4 frame, 1-bit output, all pixels 0 -> all out_pixel 0 and frame_done pulsed once, 1 cycle after the 16th out handshake.
REQ-028 SHALL be verified with a 4x4 frame, all pixels 128 -> pixel(0,0)=255 with err=-127 and pixel(0,1): adj=72, out 0.
REQ-029 SHALL be verified with random 8-bit 4x4 frames with OUT_BITS 1 and 2 -> every output matches a reference model implementing REQ-016..019.
REQ-030 SHALL be verified with out_ready toggled every other cycle -> no pixel lost or duplicated, and out_* stable while stalled.
REQ-031 SHALL be verified with reset asserted after 7 pixels, then a new start and a full frame -> output identical to a clean run.
REQ-032 SHALL be verified with FS_SERPENTINE_EN defined and random frames -> outputs match a serpentine reference model; start pulsed during RUN -> ignored.
